exception_seq: RTL and testbench

- Multicycle-CPU exception sequencer, directly upstream of the memory-address mux.
- Detects invalid-opcode, overflow and divide-by-zero events, saves EPC, and drives the mux select to the matching vector address (253/254/255).
- Waits out the memory read latency, then loads PC with the zero-extended vector byte.
- Owns the mux select only while the sequence runs; in IDLE it selects the PC path.

---
 rtl/exception_seq_if.sv | 32 +++
 rtl/exception_seq.sv | 161 ++++++++++++++++
 tb/tb_exception_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exception_seq_if.sv
// Memory and register-write bus between the exception sequencer and the datapath.
// The sequencer (master) drives the address-mux select, the read strobe and the
// EPC/PC write ports. The memory/datapath side (slave) returns the read data.
interface exception_seq_if;
  logic [2:0]  mem_addr_sel;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        epc_we;
  logic [31:0] epc_data;
  logic        pc_we;
  logic [31:0] pc_data;

  modport master (
    output mem_addr_sel,
    output mem_rd,
    output epc_we,
    output epc_data,
    output pc_we,
    output pc_data,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr_sel,
    input  mem_rd,
    input  epc_we,
    input  epc_data,
    input  pc_we,
    input  pc_data,
    output mem_rdata
  );
endinterface

// File: rtl/exception_seq.sv
// Multicycle-CPU exception sequencer.
// Detects invalid-opcode / overflow / divide-by-zero events in IDLE, saves EPC,
// points the memory-address mux at the matching vector (253/254/255), waits out
// the memory read latency and loads PC with the zero-extended vector byte.
// Optional build macro EXC_STATUS_EN adds sticky per-cause status bits
// (exc_status) with a synchronous clear (status_clr).
module exception_seq #(
  parameter int unsigned MEM_LAT   = 2,      // read latency, legal 1..15
  parameter logic [31:0] PC_OFFSET = 32'd4   // PC already incremented at detection
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic [31:0] pc_cur,
`ifdef EXC_STATUS_EN
  input  logic        status_clr,
  output logic [2:0]  exc_status,
`endif
  exception_seq_if.master bus,
  output logic [1:0]  cause,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAVE = 2'd1,
    WAIT = 2'd2,
    LOAD = 2'd3
  } state_t;

  // Counter preload: WAIT lasts MEM_LAT-1 cycles so LOAD lands on valid data.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);
  localparam bit         HAS_WAIT = (MEM_LAT > 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  cause_q;
  logic [31:0] epc_q;
  logic [2:0]  sel_q;
  logic        mem_rd_q;
  logic        epc_we_q;
  logic        pc_we_q;
  logic        done_q;
  logic        busy_q;

  logic        exc_any;
  logic [1:0]  cause_d;

  // Priority encode the incoming events: opcode > ovf > div0.
  always_comb begin
    cause_d = 2'd0;
    if (exc_opcode)      cause_d = 2'd1;
    else if (exc_ovf)    cause_d = 2'd2;
    else if (exc_div0)   cause_d = 2'd3;
  end

  assign exc_any = exc_opcode | exc_ovf | exc_div0;

  // Sequencer FSM with registered control outputs decoded on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      cause_q  <= 2'd0;
      epc_q    <= 32'd0;
      sel_q    <= 3'd0;
      mem_rd_q <= 1'b0;
      epc_we_q <= 1'b0;
      pc_we_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (exc_any) begin
            state_q  <= SAVE;
            cause_q  <= cause_d;
            epc_q    <= pc_cur - PC_OFFSET;
            sel_q    <= {1'b0, cause_d} + 3'd1;
            mem_rd_q <= 1'b1;
            epc_we_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        SAVE: begin
          mem_rd_q <= 1'b0;
          epc_we_q <= 1'b0;
          cnt_q    <= CNT_INIT;
          if (HAS_WAIT) begin
            state_q <= WAIT;
          end else begin
            state_q <= LOAD;
            pc_we_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= LOAD;
            pc_we_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= IDLE;
          sel_q   <= 3'd0;
          pc_we_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef EXC_STATUS_EN
  logic [2:0] status_q;
  logic [2:0] status_set;

  // Status set sources: serviced cause on SAVE entry, any event seen while busy.
  always_comb begin
    status_set = 3'b000;
    if (state_q == IDLE) begin
      if (exc_any) begin
        status_set[cause_d - 2'd1] = 1'b1;
      end
    end else begin
      status_set = {exc_div0, exc_ovf, exc_opcode};
    end
  end

  // Sticky status bits; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 3'b000;
    end else begin
      status_q <= (status_clr ? 3'b000 : status_q) | status_set;
    end
  end

  assign exc_status = status_q;
`endif

  assign bus.mem_addr_sel = sel_q;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.epc_we       = epc_we_q;
  assign bus.epc_data     = epc_we_q ? epc_q : 32'd0;
  assign bus.pc_we        = pc_we_q;
  // Read data is only valid in LOAD, so it is gated rather than registered.
  assign bus.pc_data      = pc_we_q ? {24'd0, bus.mem_rdata[7:0]} : 32'd0;
  assign cause            = cause_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_exception_seq.sv
// Directed bench for exception_seq: a MEM_LAT=2 instance and a MEM_LAT=1 instance.
module tb_exception_seq;

  logic        clk;
  logic        rst_n;
  logic        exc_opcode, exc_ovf, exc_div0;
  logic [31:0] pc_cur;
  logic [1:0]  cause;
  logic        busy, done;

  logic        exc2_opcode, exc2_ovf, exc2_div0;
  logic [31:0] pc_cur2;
  logic [1:0]  cause2;
  logic        busy2, done2;

  int n_cmp;
  int n_fail;

  exception_seq_if bus1 ();
  exception_seq_if bus2 ();

`ifdef EXC_STATUS_EN
  logic       status_clr, status_clr2;
  logic [2:0] exc_status, exc_status2;
`endif

  exception_seq #(.MEM_LAT(2), .PC_OFFSET(32'd4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .exc_opcode (exc_opcode),
    .exc_ovf    (exc_ovf),
    .exc_div0   (exc_div0),
    .pc_cur     (pc_cur),
`ifdef EXC_STATUS_EN
    .status_clr (status_clr),
    .exc_status (exc_status),
`endif
    .bus        (bus1),
    .cause      (cause),
    .busy       (busy),
    .done       (done)
  );

  exception_seq #(.MEM_LAT(1), .PC_OFFSET(32'd4)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .exc_opcode (exc2_opcode),
    .exc_ovf    (exc2_ovf),
    .exc_div0   (exc2_div0),
    .pc_cur     (pc_cur2),
`ifdef EXC_STATUS_EN
    .status_clr (status_clr2),
    .exc_status (exc_status2),
`endif
    .bus        (bus2),
    .cause      (cause2),
    .busy       (busy2),
    .done       (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle1(input string tag);
    check({tag, ".sel"},    {29'd0, bus1.mem_addr_sel}, 32'd0);
    check({tag, ".busy"},   {31'd0, busy},              32'd0);
    check({tag, ".pc_we"},  {31'd0, bus1.pc_we},        32'd0);
    check({tag, ".done"},   {31'd0, done},              32'd0);
    check({tag, ".epc_we"}, {31'd0, bus1.epc_we},       32'd0);
    check({tag, ".mem_rd"}, {31'd0, bus1.mem_rd},       32'd0);
    check({tag, ".pcdat"},  bus1.pc_data,               32'd0);
    check({tag, ".epcdat"}, bus1.epc_data,              32'd0);
  endtask

  initial begin
    int dones;
    int pcwes;
    n_cmp  = 0;
    n_fail = 0;
    rst_n = 1'b0;
    exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0; pc_cur = 32'd0;
    exc2_opcode = 1'b0; exc2_ovf = 1'b0; exc2_div0 = 1'b0; pc_cur2 = 32'd0;
    bus1.mem_rdata = 32'd0;
    bus2.mem_rdata = 32'd0;
`ifdef EXC_STATUS_EN
    status_clr = 1'b0; status_clr2 = 1'b0;
`endif
    #2;
    check_idle1("reset");
    check("reset.cause", {30'd0, cause}, 32'd0);
    check("reset.busy2", {31'd0, busy2}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Test 1: overflow pulse, MEM_LAT=2
    pc_cur  = 32'h40;
    exc_ovf = 1'b1;
    step();
    exc_ovf = 1'b0;
    check("t1.c1.epc_we", {31'd0, bus1.epc_we},       32'd1);
    check("t1.c1.epcdat", bus1.epc_data,               32'h3C);
    check("t1.c1.sel",    {29'd0, bus1.mem_addr_sel},  32'd3);
    check("t1.c1.mem_rd", {31'd0, bus1.mem_rd},        32'd1);
    check("t1.c1.busy",   {31'd0, busy},               32'd1);
    check("t1.c1.cause",  {30'd0, cause},              32'd2);
    check("t1.c1.pc_we",  {31'd0, bus1.pc_we},         32'd0);
    step();
    check("t1.c2.epc_we", {31'd0, bus1.epc_we},        32'd0);
    check("t1.c2.epcdat", bus1.epc_data,               32'd0);
    check("t1.c2.mem_rd", {31'd0, bus1.mem_rd},        32'd0);
    check("t1.c2.sel",    {29'd0, bus1.mem_addr_sel},  32'd3);
    check("t1.c2.pc_we",  {31'd0, bus1.pc_we},         32'd0);
    bus1.mem_rdata = 32'h12345678;
    step();
    check("t1.c3.pc_we",  {31'd0, bus1.pc_we},         32'd1);
    check("t1.c3.pcdat",  bus1.pc_data,                32'h78);
    check("t1.c3.done",   {31'd0, done},               32'd1);
    check("t1.c3.sel",    {29'd0, bus1.mem_addr_sel},  32'd3);
    check("t1.c3.busy",   {31'd0, busy},               32'd1);
    step();
    check_idle1("t1.c4");
    check("t1.c4.cause",  {30'd0, cause},              32'd2);

    // Test 3: div0 while busy is dropped
`ifdef EXC_STATUS_EN
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check("t3.stat_clr", {29'd0, exc_status}, 32'd0);
`endif
    exc_ovf = 1'b1;
    step();
    exc_ovf  = 1'b0;
    exc_div0 = 1'b1;
    check("t3.sel", {29'd0, bus1.mem_addr_sel}, 32'd3);
    dones = 0;
    step();
    exc_div0 = 1'b0;
    dones += int'(done);
    for (int i = 0; i < 5; i++) begin
      step();
      dones += int'(done);
    end
    check("t3.dones", dones,                   32'd1);
    check("t3.cause", {30'd0, cause},          32'd2);
    check("t3.busy",  {31'd0, busy},           32'd0);
`ifdef EXC_STATUS_EN
    check("t3.status", {29'd0, exc_status},    32'b110);
`endif

    // Test 2: simultaneous events, opcode wins
    exc_opcode = 1'b1; exc_ovf = 1'b1; exc_div0 = 1'b1;
    pc_cur = 32'h100;
    step();
    exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;
    check("t2.cause",  {30'd0, cause},             32'd1);
    check("t2.sel",    {29'd0, bus1.mem_addr_sel}, 32'd2);
    check("t2.epcdat", bus1.epc_data,              32'hFC);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      dones += int'(done);
    end
    check("t2.dones", dones,          32'd1);
    check("t2.busy",  {31'd0, busy},  32'd0);

    // Test 4: asynchronous reset during WAIT
    exc_div0 = 1'b1;
    step();
    exc_div0 = 1'b0;
    step();
    check("t4.wait.busy", {31'd0, busy},               32'd1);
    check("t4.wait.sel",  {29'd0, bus1.mem_addr_sel},  32'd4);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle1("t4.rst");
    check("t4.rst.cause", {30'd0, cause}, 32'd0);
    step();
    rst_n = 1'b1;
    pcwes = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      pcwes += int'(bus1.pc_we);
    end
    check("t4.pcwes", pcwes,         32'd0);
    check("t4.busy",  {31'd0, busy}, 32'd0);

    // Test 5: MEM_LAT=1, pc_cur=0 wraps
    pc_cur2   = 32'd0;
    exc2_div0 = 1'b1;
    step();
    exc2_div0 = 1'b0;
    check("t5.c1.epc_we", {31'd0, bus2.epc_we},       32'd1);
    check("t5.c1.epcdat", bus2.epc_data,              32'hFFFFFFFC);
    check("t5.c1.sel",    {29'd0, bus2.mem_addr_sel}, 32'd4);
    check("t5.c1.mem_rd", {31'd0, bus2.mem_rd},       32'd1);
    bus2.mem_rdata = 32'h000000AB;
    step();
    check("t5.c2.pc_we",  {31'd0, bus2.pc_we},        32'd1);
    check("t5.c2.pcdat",  bus2.pc_data,               32'hAB);
    check("t5.c2.done",   {31'd0, done2},             32'd1);
    check("t5.c2.sel",    {29'd0, bus2.mem_addr_sel}, 32'd4);
    step();
    check("t5.c3.busy",   {31'd0, busy2},             32'd0);
    check("t5.c3.sel",    {29'd0, bus2.mem_addr_sel}, 32'd0);
    check("t5.c3.cause",  {30'd0, cause2},            32'd3);

    // Test 6: opcode held high for 10 edges, done every 4th cycle
    exc_opcode = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("t6.done%0d", k), {31'd0, done}, ((k % 4) == 3) ? 32'd1 : 32'd0);
    end
    exc_opcode = 1'b0;
    step();
    check("t6.done11", {31'd0, done}, 32'd1);
    step();
    check("t6.busy12", {31'd0, busy}, 32'd0);
    step();
    check("t6.busy13", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
